// File: rtl/riscv_pipe_defs_pkg.sv
// Shared RISC-V pipeline definitions: default widths, the canonical NOP encoding and
// the IF/ID buffer occupancy states, encoded as {main_valid, skid_valid}.
package riscv_pipe_defs_pkg;

    localparam int XLEN       = 64;
    localparam int DEF_PC_W   = XLEN;
    localparam int DEF_INST_W = 32;

    localparam logic [31:0] RV_NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } stage_state_e;

endpackage

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage with a main + skid entry, flush, hazard stall and NOP bubble output.
// Optional PIPE_STAGE_PERF_EN adds saturating stall_cnt / flush_cnt performance counters.
module if_id_skid_stage
    import riscv_pipe_defs_pkg::*;
#(
    parameter int                 PC_W     = DEF_PC_W,
    parameter int                 INST_W   = DEF_INST_W,
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(RV_NOP_INST)
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int                 CNT_W    = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic              in_ready_q,   in_ready_d;
    logic [PC_W-1:0]   main_pc_q,    main_pc_d;
    logic [INST_W-1:0] main_inst_q,  main_inst_d;
    logic [PC_W-1:0]   skid_pc_q,    skid_pc_d;
    logic [INST_W-1:0] skid_inst_q,  skid_inst_d;

    stage_state_e state;
    logic         take;
    logic         acc;

    assign take = main_valid_q & out_ready & ~stall;
    assign acc  = in_valid & in_ready_q;

    always_comb begin
        state        = stage_state_e'({main_valid_q, skid_valid_q});
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_pc_d    = main_pc_q;
        main_inst_d  = main_inst_q;
        skid_pc_d    = skid_pc_q;
        skid_inst_d  = skid_inst_q;

        case (state)
            ST_EMPTY: begin
                if (acc) begin
                    main_valid_d = 1'b1;
                    main_pc_d    = in_pc;
                    main_inst_d  = in_inst;
                end
            end
            ST_ONE: begin
                if (take && acc) begin
                    main_pc_d   = in_pc;
                    main_inst_d = in_inst;
                end else if (take) begin
                    main_valid_d = 1'b0;
                end else if (acc) begin
                    skid_valid_d = 1'b1;
                    skid_pc_d    = in_pc;
                    skid_inst_d  = in_inst;
                end
            end
            ST_FULL: begin
                if (take) begin
                    skid_valid_d = 1'b0;
                    main_pc_d    = skid_pc_q;
                    main_inst_d  = skid_inst_q;
                end
            end
            default: begin
                main_valid_d = 1'b0;
                skid_valid_d = 1'b0;
            end
        endcase

        // A redirect discards everything held, including a same-cycle acceptance.
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end

        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            main_pc_q    <= '0;
            main_inst_q  <= NOP_INST;
            skid_pc_q    <= '0;
            skid_inst_q  <= NOP_INST;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            main_pc_q    <= main_pc_d;
            main_inst_q  <= main_inst_d;
            skid_pc_q    <= skid_pc_d;
            skid_inst_q  <= skid_inst_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_pc    = main_valid_q ? main_pc_q   : '0;
    assign out_inst  = main_valid_q ? main_inst_q : NOP_INST;

    assert property (@(posedge clk) disable iff (reset) !(skid_valid_q && !main_valid_q));

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Flush cycles are attributed to flush_cnt only, never to stall_cnt.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (main_valid_q && !take && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (main_valid_q || skid_valid_q) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Scoreboard bench for if_id_skid_stage: directed stimulus pushes expected outputs,
// a forked monitor pops and compares on every decode-side transfer.
module tb_if_id_skid_stage;
    import riscv_pipe_defs_pkg::*;

    localparam int PC_W   = 64;
    localparam int INST_W = 32;
`ifdef PIPE_STAGE_PERF_EN
    localparam int CNT_W  = 4;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic              stall;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic [CNT_W-1:0]  stall_snap;
    logic [CNT_W-1:0]  flush_snap;
`endif

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   takes    = 0;
    int   takes0;

    always #5 clk = ~clk;

    if_id_skid_stage #(
        .PC_W     (PC_W),
        .INST_W   (INST_W),
        .NOP_INST (32'h0000_0013)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .CNT_W    (CNT_W)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    function automatic logic [INST_W-1:0] instOf(input logic [PC_W-1:0] pc);
        return 32'hA000_0000 ^ pc[31:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [PC_W-1:0] pc, input logic st,
                                 input logic fl, input logic ordy);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = instOf(pc);
        stall     = st;
        flush     = fl;
        out_ready = ordy;
    endtask

    task automatic expectOut(input logic [PC_W-1:0] pc);
        sb_q.push_back('{pc, instOf(pc)});
    endtask

    task automatic monitorLoop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready && !stall) begin
                takes++;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_out: got pc %0h expected no transfer", out_pc);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("sb_pc", out_pc, e.pc);
                    checkOutput("sb_inst", 64'(out_inst), 64'(e.inst));
                end
            end
        end
    endtask

    initial begin
        fork
            monitorLoop();
        join_none

        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(2);
        reset = 1'b0;

        // Reset held two cycles while FULL
        applyStimulus(1'b1, 64'h500, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 64'h504, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("prereset_in_ready", in_ready, 0);
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(2);
        reset = 1'b0;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_inst", 64'(out_inst), 64'h13);
        checkOutput("reset_out_pc", out_pc, 0);
`ifdef PIPE_STAGE_PERF_EN
        checkOutput("reset_stall_cnt", 64'(stall_cnt), 0);
        checkOutput("reset_flush_cnt", 64'(flush_cnt), 0);
`endif

        // Full-rate stream with one cycle of latency
        takes0 = takes;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 64'(i * 4), 1'b0, 1'b0, 1'b1);
            expectOut(64'(i * 4));
            step();
            checkOutput("stream_pc", out_pc, 64'(i * 4));
            checkOutput("stream_valid", out_valid, 1);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(2);
        checkOutput("stream_takes", 64'(takes), 64'(takes0 + 8));
        checkOutput("stream_drained", out_valid, 0);

        // Stall while fetch keeps offering: fill the skid, keep order
        applyStimulus(1'b1, 64'h100, 1'b1, 1'b0, 1'b1);
        expectOut(64'h100);
        step();
        checkOutput("one_pc", out_pc, 64'h100);
        applyStimulus(1'b1, 64'h104, 1'b1, 1'b0, 1'b1);
        expectOut(64'h104);
        step();
        checkOutput("full_in_ready", in_ready, 0);
        step(2);
        checkOutput("stall_hold_pc", out_pc, 64'h100);
        checkOutput("stall_hold_inst", 64'(out_inst), 64'(instOf(64'h100)));
        checkOutput("stall_in_ready", in_ready, 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step();
        checkOutput("unstall_second_pc", out_pc, 64'h104);
        checkOutput("unstall_in_ready", in_ready, 1);
        step();
        checkOutput("unstall_empty", out_valid, 0);

        // Flush while FULL with a new fetch offered
        applyStimulus(1'b1, 64'h300, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 64'h304, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("preflush_full", in_ready, 0);
`ifdef PIPE_STAGE_PERF_EN
        flush_snap = flush_cnt;
`endif
        applyStimulus(1'b1, 64'h200, 1'b0, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("flush_out_valid", out_valid, 0);
        checkOutput("flush_out_inst", 64'(out_inst), 64'h13);
        checkOutput("flush_out_pc", out_pc, 0);
        checkOutput("flush_in_ready", in_ready, 1);
`ifdef PIPE_STAGE_PERF_EN
        checkOutput("flush_cnt_full", 64'(flush_cnt), 64'(flush_snap + 4'd1));
        flush_snap = flush_cnt;
`endif
        // Flush in EMPTY drops the same-cycle acceptance and counts nothing
        applyStimulus(1'b1, 64'h208, 1'b0, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("flush_drop_acc", out_valid, 0);
`ifdef PIPE_STAGE_PERF_EN
        checkOutput("flush_cnt_empty", 64'(flush_cnt), 64'(flush_snap));
`endif
        step(2);
        checkOutput("flush_nothing_emitted", out_valid, 0);

        // Flush and stall together in ONE
        applyStimulus(1'b1, 64'h400, 1'b1, 1'b0, 1'b1);
        step();
        checkOutput("fs_one_valid", out_valid, 1);
`ifdef PIPE_STAGE_PERF_EN
        stall_snap = stall_cnt;
        flush_snap = flush_cnt;
`endif
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("fs_out_valid", out_valid, 0);
        checkOutput("fs_in_ready", in_ready, 1);
`ifdef PIPE_STAGE_PERF_EN
        checkOutput("fs_flush_cnt", 64'(flush_cnt), 64'(flush_snap + 4'd1));
        checkOutput("fs_stall_cnt", 64'(stall_cnt), 64'(stall_snap));
`endif

        // Long stall: entry held, stall counter saturates
        applyStimulus(1'b1, 64'h600, 1'b1, 1'b0, 1'b1);
        expectOut(64'h600);
        step();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step(20);
        checkOutput("long_stall_pc", out_pc, 64'h600);
`ifdef PIPE_STAGE_PERF_EN
        checkOutput("stall_cnt_sat", 64'(stall_cnt), 64'hF);
`endif
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step();
        checkOutput("long_stall_released", out_valid, 0);
        step(2);

        checkOutput("sb_empty", 64'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
